// File: rtl/ad_axis_pkg.sv
// rtl/ad_axis_pkg.sv - shared constants, state type and helpers for the AXI-stream arbiters
package ad_axis_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_LOCK = ST_LOCK
  } arb_state_e;

  // Index width for n channels; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ad_axis_inf_rx_arb_if.sv
// rtl/ad_axis_inf_rx_arb_if.sv - bundled stream/control signals of the receive arbiter
interface ad_axis_inf_rx_arb_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int CH_W = ad_axis_pkg::clog2(NUM_CH);

  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            s_valid;
  logic [NUM_CH-1:0]            s_last;
  logic [NUM_CH*DATA_WIDTH-1:0] s_data;
  logic [NUM_CH-1:0]            s_ready;
  logic                         m_valid;
  logic                         m_last;
  logic [DATA_WIDTH-1:0]        m_data;
  logic [CH_W-1:0]              m_chan;
  logic                         m_ready;
  logic                         busy;
  logic [CH_W-1:0]              grant;

  // Arbiter side: consumes the per-channel sources, drives the merged stream.
  modport master (
    input  ch_enable, s_valid, s_last, s_data, m_ready,
    output s_ready, m_valid, m_last, m_data, m_chan, busy, grant
  );

  // Environment side: drives the sources and the downstream ready.
  modport slave (
    output ch_enable, s_valid, s_last, s_data, m_ready,
    input  s_ready, m_valid, m_last, m_data, m_chan, busy, grant
  );

endinterface

// File: rtl/ad_rr_pick.sv
// rtl/ad_rr_pick.sv - combinational round-robin picker searching circularly after the last grant
module ad_rr_pick
  import ad_axis_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [CH_W-1:0]   idx_o,
  output logic              found_o
);

  // Two ascending passes: indices above last_i first, then wrap to those at or below it.
  always_comb begin
    idx_o   = last_i;
    found_o = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found_o && req_i[j] && (CH_W'(j) > last_i)) begin
        found_o = 1'b1;
        idx_o   = CH_W'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found_o && req_i[j] && (CH_W'(j) <= last_i)) begin
        found_o = 1'b1;
        idx_o   = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/ad_axis_inf_rx_arb.sv
// rtl/ad_axis_inf_rx_arb.sv - packet-atomic round-robin merge of NUM_CH streams into one
module ad_axis_inf_rx_arb
  import ad_axis_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  ad_axis_inf_rx_arb_if.master  bus
);

  localparam int CH_W = clog2(NUM_CH);

  arb_state_e            state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic                  busy_q;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]       m_chan_q, m_chan_d;

  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     s_ready;
  logic [CH_W-1:0]       pick_idx;
  logic                  pick_found;
  logic                  out_rdy;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;

  // Enable only gates new arbitration; an open packet keeps flowing regardless.
  assign req     = bus.s_valid & bus.ch_enable;
  assign out_rdy = bus.m_ready | ~m_valid_q;

  ad_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req_i   (req),
    .last_i  (grant_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Select the granted channel's beat and open only its ready; no s_valid term in s_ready.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    s_ready   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == CH_W'(i)) begin
        sel_valid  = bus.s_valid[i];
        sel_last   = bus.s_last[i];
        sel_data   = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
        s_ready[i] = (state_q == S_LOCK) && out_rdy;
      end
    end
  end

  assign xfer = (state_q == S_LOCK) && out_rdy && sel_valid;

  // Next state: arbitrate in IDLE, release the grant on the accepted last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (xfer && sel_last) state_d = S_IDLE;
      end
    endcase
  end

  // Output register next value: load on transfer, drain when downstream takes it.
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_chan_d  = m_chan_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_last_d  = sel_last;
      m_data_d  = sel_data;
      m_chan_d  = grant_q;
    end else if (out_rdy) begin
      m_valid_d = 1'b0;
    end
  end

  // State, grant and output registers; grant resets to the top index so channel 0 wins first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      grant_q   <= CH_W'(NUM_CH - 1);
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= (state_d == S_LOCK);
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      m_chan_q  <= m_chan_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_chan  = m_chan_q;
  assign bus.busy    = busy_q;
  assign bus.grant   = grant_q;

endmodule

// File: tb/tb_ad_axis_inf_rx_arb.sv
// tb/tb_ad_axis_inf_rx_arb.sv - scoreboard bench for the packet-atomic receive arbiter
module tb_ad_axis_inf_rx_arb;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;

  typedef struct packed {
    logic [1:0]    chan;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m_ready;
  logic          v_a [NUM_CH];
  logic          l_a [NUM_CH];
  logic [DW-1:0] d_a [NUM_CH];

  beat_t sb_q[$];
  int    order_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    gap_en   = 1'b0;
  bit    in_gap   = 1'b0;
  int    gap_cnt  = 0;
  bit    mdl_lock = 1'b0;
  int    mdl_ch   = 0;
  int    fw [8];
  int    mr [8];
  int    sr0, sr, mv;
  int    exp_rr [5];

  ad_axis_inf_rx_arb_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

  ad_axis_inf_rx_arb #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.s_valid = '0;
    bus.s_last  = '0;
    bus.s_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.s_valid[i]          = v_a[i];
      bus.s_last[i]           = l_a[i];
      bus.s_data[i*DW +: DW]  = d_a[i];
    end
    bus.m_ready = m_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one packet on channel ch; reports cycles waited for the first beat and worst later beat.
  task automatic send_pkt(input int ch, input logic [DW-1:0] base, input int n,
                          output int first_wait, output int max_rest);
    int  w;
    bit  acc;
    first_wait = 0;
    max_rest   = 0;
    for (int b = 0; b < n; b++) begin
      d_a[ch] = base + DW'(b);
      l_a[ch] = (b == n - 1);
      v_a[ch] = 1'b1;
      w   = 0;
      acc = 1'b0;
      while (!acc && w < 100) begin
        @(negedge clk);
        w++;
        acc = bus.s_ready[ch];
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        check("send_timeout", 32'(ch), 32'hffff_ffff);
        b = n;
      end
      if (b == 0) first_wait = w;
      else if (w > max_rest) max_rest = w;
    end
    v_a[ch] = 1'b0;
    l_a[ch] = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_order(input string tag, input int n, input int e0, input int e1);
    check({tag, "_n"}, 32'(order_q.size()), 32'(n));
    if (order_q.size() > 0) check({tag, "_0"}, 32'(order_q[0]), 32'(e0));
    if (order_q.size() > 1) check({tag, "_1"}, 32'(order_q[1]), 32'(e1));
  endtask

  // Monitor: pop/compare output beats, push accepted input beats, track packet bubbles.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sb_q.delete();
        in_gap   = 1'b0;
        mdl_lock = 1'b0;
      end else begin
        if (bus.m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("m_data", 32'(bus.m_data), 32'(e.data));
            check("m_chan", 32'(bus.m_chan), 32'(e.chan));
            check("m_last", 32'(bus.m_last), 32'(e.last));
          end
          if (gap_en && in_gap) check("pkt_gap", 32'(gap_cnt), 32'd1);
          in_gap = 1'b0;
          if (bus.m_last) begin
            order_q.push_back(int'(bus.m_chan));
            in_gap  = 1'b1;
            gap_cnt = 0;
          end
        end else if (!bus.m_valid && in_gap) begin
          gap_cnt++;
        end
        if (!gap_en) in_gap = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (v_a[i] && bus.s_ready[i]) begin
            if (mdl_lock) check("atomic", 32'(i), 32'(mdl_ch));
            mdl_lock = !l_a[i];
            mdl_ch   = i;
            sb_q.push_back({2'(i), d_a[i], l_a[i]});
          end
        end
      end
    end
  end

  initial begin
    exp_rr = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NUM_CH; i++) begin
      v_a[i] = 1'b0;
      l_a[i] = 1'b0;
      d_a[i] = '0;
    end
    rstn          = 1'b0;
    m_ready       = 1'b1;
    bus.ch_enable = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_last",  32'(bus.m_last),  32'd0);
    check("rst_m_data",  32'(bus.m_data),  32'd0);
    check("rst_m_chan",  32'(bus.m_chan),  32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_grant",   32'(bus.grant),   32'd3);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single channel: 4 beats on channel 2
    send_pkt(2, 16'h0010, 4, fw[0], mr[0]);
    check("arb_latency", 32'(fw[0]), 32'd2);
    check("stream_rate", 32'(mr[0]), 32'd1);
    drain();
    check("single_drain", 32'(sb_q.size()), 32'd0);

    // Round robin from a fresh reset: 0,1,2,3,0 with one bubble per packet
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    order_q.delete();
    gap_en = 1'b1;
    fork
      begin
        send_pkt(0, 16'h0100, 2, fw[0], mr[0]);
        send_pkt(0, 16'h0500, 2, fw[4], mr[4]);
      end
      send_pkt(1, 16'h0200, 2, fw[1], mr[1]);
      send_pkt(2, 16'h0300, 2, fw[2], mr[2]);
      send_pkt(3, 16'h0400, 2, fw[3], mr[3]);
    join
    gap_en = 1'b0;
    drain();
    check("rr_n", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < order_q.size()) check("rr_order", 32'(order_q[i]), 32'(exp_rr[i]));

    // Channel 1 requests while channel 0 is mid-packet
    order_q.delete();
    gap_en = 1'b1;
    fork
      send_pkt(0, 16'h0600, 4, fw[0], mr[0]);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_pkt(1, 16'h0700, 2, fw[1], mr[1]);
      end
    join
    gap_en = 1'b0;
    drain();
    check_order("midreq", 2, 0, 1);

    // Backpressure: m_ready low 5 cycles inside a channel-3 packet
    fork
      send_pkt(3, 16'h0800, 6, fw[0], mr[0]);
      begin
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_s_ready", 32'(bus.s_ready), 32'd0);
          check("bp_m_valid", 32'(bus.m_valid), 32'd1);
          check("bp_busy",    32'(bus.busy),    32'd1);
          if (sb_q.size() > 0) check("bp_hold", 32'(bus.m_data), 32'(sb_q[0].data));
          else check("bp_hold_q", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();
    check("bp_drain", 32'(sb_q.size()), 32'd0);

    // Enable mask: clear ch_enable[0] mid-packet, then channel 0 must be skipped
    order_q.delete();
    fork
      send_pkt(0, 16'h0900, 3, fw[0], mr[0]);
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.ch_enable[0] = 1'b0;
      end
    join
    v_a[0] = 1'b1;
    d_a[0] = 16'hdead;
    l_a[0] = 1'b1;
    sr0 = 0;
    fork
      send_pkt(2, 16'h0a00, 2, fw[1], mr[1]);
      repeat (8) begin
        @(negedge clk);
        if (bus.s_ready[0]) sr0++;
      end
    join
    check("mask_skip", 32'(sr0), 32'd0);
    check_order("mask", 2, 0, 2);

    // All channels valid but none enabled: nothing moves
    bus.ch_enable = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v_a[i] = 1'b1;
      l_a[i] = 1'b1;
      d_a[i] = DW'(16'h0b00 + i);
    end
    sr = 0;
    mv = 0;
    repeat (6) begin
      @(negedge clk);
      if (|bus.s_ready) sr++;
      if (bus.m_valid) mv++;
    end
    check("dis_s_ready", 32'(sr), 32'd0);
    check("dis_m_valid", 32'(mv), 32'd0);
    check("dis_busy",    32'(bus.busy),  32'd0);
    check("dis_grant",   32'(bus.grant), 32'd2);
    for (int i = 0; i < NUM_CH; i++) begin
      v_a[i] = 1'b0;
      l_a[i] = 1'b0;
    end
    bus.ch_enable = '1;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a channel-1 packet
    d_a[1] = 16'h0c00;
    l_a[1] = 1'b0;
    v_a[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ar_pre_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("ar_m_valid", 32'(bus.m_valid), 32'd0);
    check("ar_s_ready", 32'(bus.s_ready), 32'd0);
    check("ar_busy",    32'(bus.busy),    32'd0);
    check("ar_grant",   32'(bus.grant),   32'd3);
    v_a[1] = 1'b0;
    @(negedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    order_q.delete();
    fork
      send_pkt(3, 16'h0d00, 2, fw[0], mr[0]);
      send_pkt(0, 16'h0e00, 2, fw[1], mr[1]);
    join
    drain();
    check_order("ar_prio", 2, 0, 3);
    check("final_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad_axis_inf_rx_arb.md
# ad_axis_inf_rx_arb

Packet-atomic round-robin arbiter that shares one AXI-stream output between NUM_CH upstream AXI-stream sources. Each source is typically the output of a per-channel receive buffer. It sits between those per-channel receive buffers and the single downstream DMA or packer stream. A grant is held for a whole packet, from first beat to the beat with last. Each output beat carries the index of the channel that produced it.

## Interface
- NUM_CH, 4: number of requesting channels, 2..8.
- DATA_WIDTH, 16: beat width in bits.
- CH_W, derived: clog2(NUM_CH), minimum 1.
- clk  in  1  single clock for the whole block.
- rstn  in  1  asynchronous active-low reset.
- ch_enable  in  NUM_CH  per-channel arbitration enable mask.
- s_valid  in  NUM_CH  per-channel beat valid.
- s_last  in  NUM_CH  per-channel end-of-packet.
- s_data  in  NUM_CH*DATA_WIDTH  per-channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_ready  out  NUM_CH  per-channel ready.
- m_valid  out  1  output beat valid.
- m_last  out  1  output end-of-packet.
- m_data  out  DATA_WIDTH  output data.
- m_chan  out  CH_W  source channel of the current output beat.
- m_ready  in  1  downstream ready.
- busy  out  1  high while a packet grant is held.
- grant  out  CH_W  currently or last granted channel.

## Operation
- States:
  - IDLE: no grant is held.
  - LOCK: a grant is held on channel `grant`.
- Request vector: req = s_valid & ch_enable.
- In IDLE with req != 0:
  - Pick the first set bit of req, searching circularly from (grant+1) mod NUM_CH.
  - Register it into grant and go to LOCK.
  - No data moves in this cycle.
- In IDLE with req == 0: stay in IDLE; grant holds its value.
- Output-register accept: out_rdy = m_ready | ~m_valid.
- s_ready[i] = (state==LOCK) & (grant==i) & out_rdy. All other channels see ready low.
- Transfer on channel g when s_valid[g] & s_ready[g]:
  - Register m_data, m_last, m_chan=g and m_valid=1 on the next clock.
- In LOCK with out_rdy high and no transfer: m_valid goes to 0 on the next clock.
- In LOCK with out_rdy low: all m_* hold their values.
- A transfer with s_last[g]=1 moves the state to IDLE on the same clock edge.
- Clearing ch_enable[g] during LOCK does not break the packet. It only masks channel g at later arbitrations.
- A channel that is enabled but not requesting is skipped, with no wait.
- Priority after reset: grant resets to NUM_CH-1, so channel 0 has first priority.
- Reset values:
  - state = IDLE, grant = NUM_CH-1, busy = 0.
  - m_valid = 0, m_last = 0, m_data = 0, m_chan = 0.
  - s_ready = 0.
- Reset asserted mid-packet clears everything immediately. The partial packet is abandoned; there is no recovery of the remaining beats.

## Timing
- Arbitration costs 1 cycle: req seen in IDLE at cycle t, s_ready high at t+1.
- Data latency is 1 cycle: beat accepted at t, m_valid at t+1.
- Sustained throughput inside a packet is 1 beat/cycle while m_ready=1.
- Packet boundary: last accepted at t, IDLE at t+1, new grant at t+2. This gives exactly 1 bubble per packet on m_valid.
- busy is a registered copy of (state==LOCK).
- s_ready is combinational from state, grant, m_valid and m_ready. There is no combinational path from s_valid to s_ready.
- m_ready held low for any number of cycles: m_* hold stable and s_ready stays 0, so no beat is lost or duplicated.

## Structure
- Shared package ad_axis_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_LOCK=1'b1;
  - the clog2 function used for CH_W.
- Sub-module ad_rr_pick is combinational and parameterised by NUM_CH. It takes req and the last grant and returns the next index plus a found flag. It is reused by other arbiters in the codebase.
- The top module holds the state register, the grant register, the input data multiplexer indexed by grant, and the output register.

## Test plan
- Single channel: reset, then drive channel 2 with a 4-beat packet, data 0x10..0x13, last on the final beat.
  - s_ready[2] rises 1 cycle after s_valid.
  - m_data shows 0x10..0x13 on consecutive cycles, m_chan=2, m_last only on 0x13.
- Round robin: all 4 channels request continuously with 2-beat packets.
  - Grant order is 0,1,2,3,0.
  - Exactly 1 idle cycle between packets on m_valid.
- Mid-packet request: channel 1 asserts s_valid while channel 0 is mid-packet.
  - No channel-1 beat appears until after channel 0's last beat.
  - Channel 1 is granted 1 cycle after channel 0 returns to IDLE.
- Backpressure: hold m_ready=0 for 5 cycles mid-packet.
  - m_data stays constant and s_ready stays 0.
  - Release m_ready: the beat sequence continues with no gap or duplicate.
- Enable mask:
  - Clear ch_enable[0] mid-packet on channel 0: the packet completes and channel 0 is skipped afterwards.
  - ch_enable=0 with all s_valid high: state stays IDLE and m_valid stays 0.
- Async reset: drop rstn mid-packet without a clock edge.
  - m_valid=0, s_ready=0 and busy=0 immediately.
  - After release, channel 0 has priority.
